// File: rtl/relay_pkg.sv
// Shared types and constants for the relay-timed register move sequencer.
package relay_pkg;

    localparam int CNT_W = 4;
    localparam logic [1:0] OP_MOV8 = 2'b00;

    typedef enum logic [2:0] {
        REG_A  = 3'd0,
        REG_B  = 3'd1,
        REG_C  = 3'd2,
        REG_D  = 3'd3,
        REG_M1 = 3'd4,
        REG_M2 = 3'd5,
        REG_X  = 3'd6,
        REG_Y  = 3'd7
    } reg_code_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/reg_decoder_3to8.sv
// One-hot decoder from a 3-bit register code to an 8-bit strobe vector.
module reg_decoder_3to8
    import relay_pkg::*;
(
    input  reg_code_t  code,
    input  logic       en,
    output logic [7:0] onehot
);

    // Decode the register code; a disabled decoder drives nothing
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot = 8'(8'h01 << code);
        end else begin
            onehot = 8'h00;
        end
    end

endmodule

// File: rtl/reg_move_sequencer.sv
// Sequences one 8-bit MOV through the register unit with select-before-load,
// load-release-before-select strobe timing. All outputs are registered.
module reg_move_sequencer
    import relay_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOAD_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] instr,
    output logic [7:0] sel,
    output logic [7:0] ld,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_INIT   = CNT_W'(LOAD_CYCLES - 1);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    reg_code_t         src_r, src_s, dst_r, dst_s;
    logic              illegal_s;
    logic              sel_en_s, ld_en_s;
    logic [7:0]        sel_s, ld_s;
    logic [7:0]        sel_r, ld_r;
    logic              busy_r, done_r, illegal_r;

    // Next-state, counter and operand-latch logic
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        src_s     = src_r;
        dst_s     = dst_r;
        illegal_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (instr[7:6] == OP_MOV8) begin
                        dst_s   = reg_code_t'(instr[5:3]);
                        src_s   = reg_code_t'(instr[2:0]);
                        cnt_s   = SETTLE_INIT;
                        state_s = ST_SELECT;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (cnt_r == 4'd0) begin
                    cnt_s   = LOAD_INIT;
                    state_s = ST_LOAD;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_LOAD: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RELEASE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RELEASE: state_s = ST_DONE;
            ST_DONE:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so the registered outputs
    // line up with the state they describe. A self-move leaves the bus
    // undriven, so the destination loads zero.
    assign sel_en_s = ((state_s == ST_SELECT) || (state_s == ST_LOAD) ||
                       (state_s == ST_RELEASE)) && (src_s != dst_s);
    assign ld_en_s  = (state_s == ST_LOAD);

    reg_decoder_3to8 u_sel_dec (.code(src_s), .en(sel_en_s), .onehot(sel_s));
    reg_decoder_3to8 u_ld_dec  (.code(dst_s), .en(ld_en_s),  .onehot(ld_s));

    // State, operand and output registers; reset drops all strobes at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            src_r     <= REG_A;
            dst_r     <= REG_A;
            sel_r     <= 8'h00;
            ld_r      <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            src_r     <= src_s;
            dst_r     <= dst_s;
            sel_r     <= sel_s;
            ld_r      <= ld_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
            illegal_r <= illegal_s;
        end
    end

    assign sel     = sel_r;
    assign ld      = ld_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign illegal = illegal_r;

endmodule

// File: doc/reg_move_sequencer.md
Name: reg_move_sequencer

Overview:
- Sequences one 8-bit register-to-register move (MOV) through the eight 8-bit registers of the register unit: A, B, C, D, M1, M2, X, Y.
- Decodes the MOV instruction byte and drives the per-register select (drive data bus) and load (latch data bus) strobes with relay-style timing:
  - select settles before load;
  - load releases before select.
- Sits between the instruction register/decoder and the register unit control bus. The 16-bit M and XY paths are out of scope.

Parameters:
- SETTLE_CYCLES, 2, cycles the source select is held before load asserts (legal range 1..15).
- LOAD_CYCLES, 2, cycles the destination load is held together with the select (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to execute the instruction on instr; sampled only in IDLE.
- instr  input  8  instruction byte; MOV8 = 2'b00 in bits 7:6, destination ddd in bits 5:3, source sss in bits 2:0.
- sel  output  8  one-hot source select, bit index = register code.
- ld  output  8  one-hot destination load, bit index = register code.
- busy  output  1  high while a move is in progress.
- done  output  1  one-cycle pulse when a move completes.
- illegal  output  1  one-cycle pulse when start is applied with a non-MOV8 opcode.

Behaviour:
- Register codes: 0=A, 1=B, 2=C, 3=D, 4=M1, 5=M2, 6=X, 7=Y.
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, latched src/dst=0.
  - sel, ld, busy, done, illegal all 0.
  - Reset mid-move drops all strobes immediately; no done pulse.
- All outputs are registered (decoded from state and latched fields). No combinational path from start/instr to any output.
- States: IDLE, SELECT, LOAD, RELEASE, DONE.
- IDLE, start=1:
  - instr[7:6]==2'b00: latch dst=instr[5:3], src=instr[2:0], counter=SETTLE_CYCLES-1, go to SELECT.
  - Otherwise: pulse illegal for 1 cycle, stay in IDLE, no strobes.
- SELECT: sel[src]=1, ld=0.
  - Counter decrements; at 0, load LOAD_CYCLES-1 and go to LOAD.
- LOAD: sel[src]=1, ld[dst]=1.
  - At counter 0, go to RELEASE.
- RELEASE: sel[src]=1, ld=0, for 1 cycle (load breaks before select). Then go to DONE.
- DONE: all strobes 0, done=1 for 1 cycle, then IDLE.
- busy=1 in SELECT, LOAD, RELEASE and DONE.
- start outside IDLE is ignored; it is not queued.
- Timing with default parameters, start sampled in cycle 0:
  - sel high cycles 1-5.
  - ld high cycles 3-4.
  - done in cycle 6.
  - Next start accepted in cycle 7.
  - Total latency = SETTLE_CYCLES + LOAD_CYCLES + 2.
- src==dst (clear): same timing, but sel stays all-zero. The bus floats to 0, so the destination loads 0.
- Invariants: at most one sel bit and at most one ld bit high; ld never high unless in LOAD.

Decomposition:
- Shared package relay_pkg holds:
  - reg_code_t (3-bit enum A..Y);
  - state_t enum;
  - OP_MOV8 = 2'b00;
  - the counter width constant (4).
- One sub-module is natural: reg_decoder_3to8 (3-bit code plus enable in, one-hot 8 out), instanced once for sel and once for ld.

Test Plan:
- Reset, then start with instr=8'h01 (MOV A<-B), defaults:
  - sel=8'h02 in cycles 1-5;
  - ld=8'h01 in cycles 3-4 only;
  - done=1 in cycle 6;
  - busy=1 in cycles 1-6.
- instr=8'h3E (MOV Y<-X):
  - sel=8'h40 and ld=8'h80;
  - ld deasserts exactly one cycle before sel.
- instr=8'h12 (MOV C<-C, clear):
  - sel stays 8'h00 throughout;
  - ld=8'h04 in cycles 3-4;
  - done in cycle 6.
- start with instr=8'h80 → illegal=1 for exactly one cycle; busy, sel and ld remain 0.
- start pulsed again during LOAD → ignored; exactly one done pulse, and the new start is accepted only in IDLE.
- reset asserted asynchronously mid-LOAD → sel and ld go to 0 immediately, no done pulse, and a fresh MOV after release completes normally.
- SETTLE_CYCLES=1, LOAD_CYCLES=3 → sel high cycles 1-5, ld high cycles 2-4, done in cycle 6.
